// File: rtl/uart_reply_tx.sv
// Word FIFO + 8N1 serialiser: each 20-bit word leaves as 3 UART bytes.
// Latency 1 cycle from accept to start bit; send_ready drops while the FIFO is full.

module uart_reply_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= dat_i;
  end

  assign dat_o   = mem_q[rd_q];
  assign count_o = count_q;
endmodule

module uart_reply_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] send_data,
  input  logic        send_valid,
  output logic        send_ready,
  output logic        tx,
  output logic        busy
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int FW       = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [1:0]    byte_q;
  logic [19:0]   word_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic [FW:0]   fifo_cnt;
  logic [19:0]   fifo_head;
  logic          fifo_nempty;
  logic          push;
  logic          pop;
  logic          baud_end;

  assign send_ready  = (fifo_cnt != (FW+1)'(FIFO_DEPTH));
  assign push        = send_valid & send_ready;
  assign fifo_nempty = (fifo_cnt != '0);
  assign baud_end    = (baud_q == BAUD_LAST);
  // Pop from IDLE, or chain the next word straight off the last stop bit.
  assign pop = fifo_nempty &
               ((state_q == IDLE) | ((state_q == STOP) & baud_end & (byte_q == 2'd2)));

  uart_reply_fifo #(.W(20), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .dat_i   (send_data),
    .pop_i   (pop),
    .dat_o   (fifo_head),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            word_q  <= fifo_head;
            byte_q  <= 2'd0;
            shift_q <= {4'h0, fifo_head[19:16]};
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (byte_q != 2'd2) begin
              byte_q  <= byte_q + 2'd1;
              shift_q <= (byte_q == 2'd0) ? word_q[15:8] : word_q[7:0];
              tx_q    <= 1'b0;
              state_q <= START;
            end else if (pop) begin
              word_q  <= fifo_head;
              byte_q  <= 2'd0;
              shift_q <= {4'h0, fifo_head[19:16]};
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE) | fifo_nempty;
endmodule
